// File: rtl/trigger_fill_sequencer_pkg.sv
// Shared types and record layout for the trigger fill sequencer.
// Default widths, FSM encoding and field offsets of the trigger-information record.
package trig_seq_pkg;

  localparam int unsigned DEF_NCHAN = 5;
  localparam int unsigned DEF_FT_W  = 2;
  localparam int unsigned DEF_TN_W  = 64;
  localparam int unsigned DEF_TO_W  = 24;
  localparam int unsigned CNT_W     = 32;

  localparam int unsigned REC_W = DEF_TN_W + DEF_FT_W + 2 * DEF_NCHAN;

  // Record layout {trig_num, fill_type, chan_mask, to_mask}, MSB first
  localparam int unsigned TO_MASK_LSB   = 0;
  localparam int unsigned CHAN_MASK_LSB = DEF_NCHAN;
  localparam int unsigned FT_LSB        = 2 * DEF_NCHAN;
  localparam int unsigned TN_LSB        = 2 * DEF_NCHAN + DEF_FT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STORE = 2'd2
  } state_e;

  function automatic int unsigned rec_w(int unsigned nchan, int unsigned ft_w,
                                        int unsigned tn_w);
    return tn_w + ft_w + 2 * nchan;
  endfunction

endpackage

// File: rtl/trigger_fill_sequencer_if.sv
// Channel-FPGA acquisition lines and trigger-information FIFO write port.
interface trigger_fill_sequencer_if #(
  parameter int unsigned NCHAN = trig_seq_pkg::DEF_NCHAN,
  parameter int unsigned FT_W  = trig_seq_pkg::DEF_FT_W,
  parameter int unsigned TN_W  = trig_seq_pkg::DEF_TN_W
) ();

  localparam int unsigned RecW = trig_seq_pkg::rec_w(NCHAN, FT_W, TN_W);

  logic [NCHAN-1:0]      acq_trig;
  logic [NCHAN*FT_W-1:0] acq_enable;
  logic [NCHAN-1:0]      acq_done;
  logic                  fifo_valid;
  logic                  fifo_ready;
  logic [RecW-1:0]       fifo_data;

  modport master (
    output acq_trig, acq_enable, fifo_valid, fifo_data,
    input  acq_done, fifo_ready
  );

  modport slave (
    input  acq_trig, acq_enable, fifo_valid, fifo_data,
    output acq_done, fifo_ready
  );

endinterface

// File: rtl/trigger_fill_sequencer_done_collector.sv
// Sticky per-channel done accumulation and fill timeout for one fill.
// complete/timeout are combinational so the FSM can act in the same cycle.
module done_collector #(
  parameter int unsigned NCHAN = trig_seq_pkg::DEF_NCHAN,
  parameter int unsigned TO_W  = trig_seq_pkg::DEF_TO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [NCHAN-1:0] mask_i,
  input  logic [NCHAN-1:0] acq_done_i,
  input  logic [TO_W-1:0]  timeout_cycles_i,
  output logic             complete_c_o,
  output logic             timeout_c_o,
  output logic [NCHAN-1:0] to_mask_c_o
);

  logic [NCHAN-1:0] sticky_q, sticky_d, sticky_next;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             limit_hit;

  // Same-cycle done counts towards completion; completion beats timeout
  always_comb begin
    sticky_next  = sticky_q | (acq_done_i & mask_i);
    limit_hit    = (timeout_cycles_i != '0) &&
                   (timer_q == timeout_cycles_i - TO_W'(1));
    complete_c_o = en_i && (sticky_next == mask_i);
    timeout_c_o  = en_i && limit_hit && !complete_c_o;
    to_mask_c_o  = mask_i & ~sticky_next;
  end

  always_comb begin
    sticky_d = sticky_q;
    timer_d  = timer_q;
    if (clear_i) begin
      sticky_d = '0;
      timer_d  = '0;
    end else if (en_i) begin
      sticky_d = sticky_next;
      timer_d  = timer_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
      timer_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: rtl/trigger_fill_sequencer.sv
// Accepts global triggers, drives a masked fill on the Channel FPGAs and
// pushes one trigger-information record per fill into the command-manager FIFO.
module trigger_fill_sequencer
  import trig_seq_pkg::*;
#(
  parameter int unsigned NCHAN = DEF_NCHAN,
  parameter int unsigned FT_W  = DEF_FT_W,
  parameter int unsigned TN_W  = DEF_TN_W,
  parameter int unsigned TO_W  = DEF_TO_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trigger_i,
  input  logic [NCHAN-1:0]        chan_en_i,
  input  logic [FT_W-1:0]         fill_type_i,
  input  logic [TO_W-1:0]         timeout_cycles_i,
  output logic [TN_W-1:0]         trig_num_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        dropped_cnt_o,
  output logic                    timeout_err_o,
  trigger_fill_sequencer_if.master bus
);

  localparam int unsigned RecW = rec_w(NCHAN, FT_W, TN_W);

  state_e                state_q, state_d;
  logic [TN_W-1:0]       trig_num_q, trig_num_d;
  logic [NCHAN-1:0]      mask_q, mask_d;
  logic [FT_W-1:0]       ft_q, ft_d;
  logic [NCHAN-1:0]      acq_trig_q, acq_trig_d;
  logic [NCHAN*FT_W-1:0] acq_enable_q, acq_enable_d;
  logic                  fifo_valid_q, fifo_valid_d;
  logic [RecW-1:0]       fifo_data_q, fifo_data_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      dropped_q, dropped_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  clear;
  logic                  complete_c;
  logic                  timeout_c;
  logic [NCHAN-1:0]      to_mask_c;

  done_collector #(
    .NCHAN (NCHAN),
    .TO_W  (TO_W)
  ) u_done_collector (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clear),
    .en_i             (state_q == FILL),
    .mask_i           (mask_q),
    .acq_done_i       (bus.acq_done),
    .timeout_cycles_i (timeout_cycles_i),
    .complete_c_o     (complete_c),
    .timeout_c_o      (timeout_c),
    .to_mask_c_o      (to_mask_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    trig_num_d    = trig_num_q;
    mask_d        = mask_q;
    ft_d          = ft_q;
    acq_trig_d    = acq_trig_q;
    acq_enable_d  = acq_enable_q;
    fifo_valid_d  = fifo_valid_q;
    fifo_data_d   = fifo_data_q;
    dropped_d     = dropped_q;
    timeout_err_d = timeout_err_q;
    clear         = 1'b0;

    if (trigger_i && (state_q != IDLE) && (dropped_q != '1)) begin
      dropped_d = dropped_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          trig_num_d = trig_num_q + TN_W'(1);
          mask_d     = chan_en_i;
          ft_d       = fill_type_i;
          clear      = 1'b1;
          if (chan_en_i != '0) begin
            state_d      = FILL;
            acq_trig_d   = chan_en_i;
            acq_enable_d = {NCHAN{fill_type_i}};
          end else begin
            // Empty mask: nothing to wait for, record goes straight out
            state_d      = STORE;
            fifo_valid_d = 1'b1;
            fifo_data_d  = {trig_num_d, fill_type_i, {NCHAN{1'b0}}, {NCHAN{1'b0}}};
          end
        end
      end
      FILL: begin
        if (complete_c || timeout_c) begin
          state_d      = STORE;
          acq_trig_d   = '0;
          acq_enable_d = '0;
          fifo_valid_d = 1'b1;
          fifo_data_d  = {trig_num_q, ft_q, mask_q,
                          timeout_c ? to_mask_c : {NCHAN{1'b0}}};
          if (timeout_c) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      STORE: begin
        if (bus.fifo_ready) begin
          state_d      = IDLE;
          fifo_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      trig_num_q    <= '0;
      mask_q        <= '0;
      ft_q          <= '0;
      acq_trig_q    <= '0;
      acq_enable_q  <= '0;
      fifo_valid_q  <= 1'b0;
      fifo_data_q   <= '0;
      busy_q        <= 1'b0;
      dropped_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_num_q    <= trig_num_d;
      mask_q        <= mask_d;
      ft_q          <= ft_d;
      acq_trig_q    <= acq_trig_d;
      acq_enable_q  <= acq_enable_d;
      fifo_valid_q  <= fifo_valid_d;
      fifo_data_q   <= fifo_data_d;
      busy_q        <= busy_d;
      dropped_q     <= dropped_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign trig_num_o     = trig_num_q;
  assign busy_o         = busy_q;
  assign dropped_cnt_o  = dropped_q;
  assign timeout_err_o  = timeout_err_q;
  assign bus.acq_trig   = acq_trig_q;
  assign bus.acq_enable = acq_enable_q;
  assign bus.fifo_valid = fifo_valid_q;
  assign bus.fifo_data  = fifo_data_q;

endmodule

// File: tb/tb_trigger_fill_sequencer.sv
// Directed bench for trigger_fill_sequencer; records are checked by a FIFO-side monitor.
module tb_trigger_fill_sequencer;
  import trig_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [4:0]  chan_en = '0;
  logic [1:0]  fill_type = '0;
  logic [23:0] timeout_cycles = '0;
  logic [63:0] trig_num;
  logic        busy;
  logic [31:0] dropped_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int n_rec  = 0;
  logic [REC_W-1:0] exp_q[$];
  logic             hold = 1'b0;
  logic [REC_W-1:0] held_data = '0;

  always #5 clk = ~clk;

  trigger_fill_sequencer_if #(.NCHAN(5), .FT_W(2), .TN_W(64)) bus ();

  trigger_fill_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .trigger_i        (trigger),
    .chan_en_i        (chan_en),
    .fill_type_i      (fill_type),
    .timeout_cycles_i (timeout_cycles),
    .trig_num_o       (trig_num),
    .busy_o           (busy),
    .dropped_cnt_o    (dropped_cnt),
    .timeout_err_o    (timeout_err),
    .bus              (bus.master)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input logic [63:0] tn, input logic [1:0] ft,
                                                input logic [4:0] m, input logic [4:0] to);
    logic [REC_W-1:0] r;
    r = '0;
    r[TN_LSB +: 64]       = tn;
    r[FT_LSB +: 2]        = ft;
    r[CHAN_MASK_LSB +: 5] = m;
    r[TO_MASK_LSB +: 5]   = to;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("wait_idle", 128'(busy), 128'(0));
  endtask

  // FIFO-side monitor: pops the scoreboard on each transfer, checks hold stability
  always @(negedge clk) begin
    if (reset) begin
      hold <= 1'b0;
    end else if (bus.fifo_valid) begin
      if (hold) chk("fifo_data_stable", 128'(bus.fifo_data), 128'(held_data));
      if (bus.fifo_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got %0h, expected none", bus.fifo_data);
        end else begin
          chk("record", 128'(bus.fifo_data), 128'(exp_q.pop_front()));
        end
        n_rec++;
      end
      hold      <= !bus.fifo_ready;
      held_data <= bus.fifo_data;
    end else begin
      hold <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit at, seen;
    int n;
    bus.acq_done   = '0;
    bus.fifo_ready = 1'b1;
    repeat (3) step();
    chk("rst_state", {84'(0), trig_num, dropped_cnt, 12'(0)}, 128'(0));
    chk("rst_outs", {bus.acq_trig, bus.acq_enable, bus.fifo_valid, busy, timeout_err}, 128'(0));
    chk("rst_fifo_data", 128'(bus.fifo_data), 128'(0));
    reset = 1'b0;
    step();

    // Fill 1: three channels, dones on separate cycles
    chan_en = 5'b10101; fill_type = 2'b10; trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t1_acq_trig", 128'(bus.acq_trig), 128'(5'b10101));
    chk("t1_acq_enable", 128'(bus.acq_enable), 128'(10'b1010101010));
    chk("t1_trig_num", 128'(trig_num), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    exp_q.push_back(make_rec(64'd1, 2'b10, 5'b10101, 5'b00000));
    bus.acq_done = 5'b00001; step();
    bus.acq_done = 5'b00100; step();
    bus.acq_done = 5'b00000; step();
    chk("t1_not_early", {bus.fifo_valid, bus.acq_trig}, {122'(0), 1'b0, 5'b10101});
    bus.acq_done = 5'b10000; step();
    bus.acq_done = 5'b00000;
    chk("t1_store_entry", {bus.fifo_valid, bus.acq_trig, bus.acq_enable}, {112'(0), 1'b1, 15'(0)});
    step();
    chk("t1_valid_once", {busy, bus.fifo_valid}, 128'(0));

    // Fill 2: timeout after 100 FILL cycles with channel 1 missing
    timeout_cycles = 24'd100; chan_en = 5'b00011; fill_type = 2'b01; trigger = 1'b1;
    step();
    trigger = 1'b0;
    exp_q.push_back(make_rec(64'd2, 2'b01, 5'b00011, 5'b00010));
    bus.acq_done = 5'b00001;
    n = 0;
    while (bus.acq_trig != '0 && n < 300) begin
      step();
      bus.acq_done = '0;
      n++;
    end
    chk("t2_fill_cycles", 128'(n), 128'(100));
    chk("t2_valid", 128'(bus.fifo_valid), 128'(1));
    chk("t2_timeout_err", 128'(timeout_err), 128'(1));
    wait_idle(10);

    // Fill 3: FIFO back-pressure for 20 cycles with three dropped triggers
    timeout_cycles = '0; bus.fifo_ready = 1'b0;
    chan_en = 5'b00001; fill_type = 2'b11; trigger = 1'b1;
    step();
    trigger = 1'b0;
    bus.acq_done = 5'b00001; step();
    bus.acq_done = 5'b00000;
    exp_q.push_back(make_rec(64'd3, 2'b11, 5'b00001, 5'b00000));
    for (int i = 0; i < 20; i++) begin
      chk("t3_store_hold", {bus.fifo_valid, bus.fifo_data},
          {51'(0), 1'b1, make_rec(64'd3, 2'b11, 5'b00001, 5'b00000)});
      trigger = (i == 3 || i == 8 || i == 15);
      step();
      trigger = 1'b0;
    end
    chk("t3_dropped", 128'(dropped_cnt), 128'(3));
    chk("t3_trig_num", 128'(trig_num), 128'(3));
    bus.fifo_ready = 1'b1;
    wait_idle(10);

    // Fill 4: empty mask goes straight to STORE
    chan_en = 5'b00000; fill_type = 2'b01; trigger = 1'b1;
    exp_q.push_back(make_rec(64'd4, 2'b01, 5'b00000, 5'b00000));
    step();
    trigger = 1'b0;
    at = 1'b0; seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (bus.acq_trig != '0) at = 1'b1;
      if (bus.fifo_valid && i <= 2) seen = 1'b1;
      step();
    end
    chk("t4_no_acq_trig", 128'(at), 128'(0));
    chk("t4_record_by_cycle2", 128'(seen), 128'(1));
    wait_idle(10);

    // Reset in the middle of a fill
    chan_en = 5'b11111; fill_type = 2'b10; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    chk("t5_abort", {bus.acq_trig, bus.fifo_valid, busy, timeout_err}, 128'(0));
    chk("t5_counters", {trig_num, dropped_cnt}, 128'(0));
    reset = 1'b0;
    step();

    // Done and timeout in the same cycle: completion wins
    timeout_cycles = 24'd4; chan_en = 5'b00100; fill_type = 2'b00; trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t6_trig_num", 128'(trig_num), 128'(1));
    exp_q.push_back(make_rec(64'd1, 2'b00, 5'b00100, 5'b00000));
    step(); step(); step();
    bus.acq_done = 5'b00100; step();
    bus.acq_done = 5'b00000;
    chk("t6_valid", 128'(bus.fifo_valid), 128'(1));
    chk("t6_timeout_err", 128'(timeout_err), 128'(0));
    wait_idle(10);

    repeat (3) step();
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("record_count", 128'(n_rec), 128'(5));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
